// File: rtl/alu_decode_stage.sv
// RV32I decode stage: decodes an instruction into ALU control, buffers it in an in-order FIFO.
// Optional build macro ALU_DEC_ILLEGAL_EN flags undefined encodings on the illegal output.

`ifndef ADD
`define ADD            4'd0
`endif
`ifndef SUBTRACT
`define SUBTRACT       4'd1
`endif
`ifndef ALU_AND
`define ALU_AND        4'd2
`endif
`ifndef ALU_OR
`define ALU_OR         4'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR        4'd4
`endif
`ifndef ALU_SLTI_CMP
`define ALU_SLTI_CMP   4'd5
`endif
`ifndef ALU_SLTIU_CMP
`define ALU_SLTIU_CMP  4'd6
`endif
`ifndef ALU_SLL
`define ALU_SLL        4'd7
`endif
`ifndef ALU_SRL
`define ALU_SRL        4'd8
`endif
`ifndef ALU_SRA
`define ALU_SRA        4'd9
`endif

module alu_decode_stage #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src,
   output logic [31:0] imm,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        reg_write,
   output logic        illegal
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [3:0]  alu_ctrl;
      logic        alu_src;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
   } entry_t;

   // ---------------------------------------------------------------- decode
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic        f7_ok;
   logic        undef;
   logic [3:0]  dec_ctrl;
   logic        dec_src;
   logic [31:0] dec_imm;
   logic        dec_write;
   entry_t      dec;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign f7_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   // Shared funct3 map for OP and OP-IMM; alt selects SUB/SRA where applicable.
   function automatic logic [3:0] f3_alu(input logic [2:0] f3, input logic alt_sub, input logic alt_sra);
      logic [3:0] code;
      case (f3)
         3'b000:  code = alt_sub ? `SUBTRACT : `ADD;
         3'b001:  code = `ALU_SLL;
         3'b010:  code = `ALU_SLTI_CMP;
         3'b011:  code = `ALU_SLTIU_CMP;
         3'b100:  code = `ALU_XOR;
         3'b101:  code = alt_sra ? `ALU_SRA : `ALU_SRL;
         3'b110:  code = `ALU_OR;
         default: code = `ALU_AND;
      endcase
      return code;
   endfunction

   always_comb begin
      dec_ctrl  = `ADD;
      dec_src   = 1'b0;
      dec_imm   = 32'd0;
      dec_write = 1'b0;
      undef     = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_ctrl  = f3_alu(funct3, funct7[5], funct7[5]);
            dec_write = 1'b1;
            undef     = !f7_ok;
         end
         OPC_OP_IMM: begin
            dec_ctrl  = f3_alu(funct3, 1'b0, funct7[5]);
            dec_src   = 1'b1;
            dec_imm   = imm_i;
            dec_write = 1'b1;
            undef     = ((funct3 == 3'b001) || (funct3 == 3'b101)) && !f7_ok;
         end
         OPC_LOAD: begin
            dec_src   = 1'b1;
            dec_imm   = imm_i;
            dec_write = 1'b1;
         end
         OPC_STORE: begin
            dec_src   = 1'b1;
            dec_imm   = imm_s;
         end
         OPC_BRANCH: begin
            dec_imm = imm_b;
            case (funct3)
               3'b000, 3'b001: dec_ctrl = `SUBTRACT;
               3'b100, 3'b101: dec_ctrl = `ALU_SLTI_CMP;
               3'b110, 3'b111: dec_ctrl = `ALU_SLTIU_CMP;
               default:        undef    = 1'b1;
            endcase
         end
         default: undef = 1'b1;
      endcase
      // Undefined encodings become an inert ADD that writes nothing.
      if (undef) begin
         dec_ctrl  = `ADD;
         dec_src   = 1'b0;
         dec_imm   = 32'd0;
         dec_write = 1'b0;
      end
   end

   always_comb begin
      dec.alu_ctrl  = dec_ctrl;
      dec.alu_src   = dec_src;
      dec.imm       = dec_imm;
      dec.rs1       = instr[19:15];
      dec.rs2       = instr[24:20];
      dec.rd        = instr[11:7];
      dec.reg_write = dec_write;
`ifdef ALU_DEC_ILLEGAL_EN
      dec.illegal   = undef;
`else
      dec.illegal   = 1'b0;
`endif
   end

   // ---------------------------------------------------------------- fifo
   entry_t          mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   entry_t          head;

   assign in_ready  = (count != CW'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= dec;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head      = mem[rd_ptr];
   assign alu_ctrl  = head.alu_ctrl;
   assign alu_src   = head.alu_src;
   assign imm       = head.imm;
   assign rs1       = head.rs1;
   assign rs2       = head.rs2;
   assign rd        = head.rd;
   assign reg_write = head.reg_write;
   assign illegal   = head.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed scenarios plus a randomized run
// against a queue-based reference model. Honours ALU_DEC_ILLEGAL_EN like the design.

module tb_alu_decode_stage;

   localparam int DEPTH = 2;

   localparam logic [3:0] C_ADD  = 4'd0;
   localparam logic [3:0] C_SUB  = 4'd1;
   localparam logic [3:0] C_AND  = 4'd2;
   localparam logic [3:0] C_OR   = 4'd3;
   localparam logic [3:0] C_XOR  = 4'd4;
   localparam logic [3:0] C_SLT  = 4'd5;
   localparam logic [3:0] C_SLTU = 4'd6;
   localparam logic [3:0] C_SLL  = 4'd7;
   localparam logic [3:0] C_SRL  = 4'd8;
   localparam logic [3:0] C_SRA  = 4'd9;

`ifdef ALU_DEC_ILLEGAL_EN
   localparam logic ILL_EN = 1'b1;
`else
   localparam logic ILL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  ctrl;
      logic        src;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        rw;
      logic        ill;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  alu_ctrl;
   logic        alu_src;
   logic [31:0] imm;
   logic [4:0]  rs1, rs2, rd;
   logic        reg_write;
   logic        illegal;
   op_t         got;

   int total = 0;
   int bad = 0;

   alu_decode_stage #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm(imm),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .reg_write(reg_write), .illegal(illegal)
   );

   always #5 clk = ~clk;

   assign got = {alu_ctrl, alu_src, imm, rs1, rs2, rd, reg_write, illegal};

   // Reference decode from the instruction-set rules; care marks fields the rules define.
   function automatic op_t ref_op(input logic [31:0] i, output op_t care);
      logic [3:0] by_f3 [8];
      logic [2:0] f3;
      logic [6:0] f7;
      bit         f7_std;
      bit         legal;
      int         ival, sval, bval;
      op_t        r;
      by_f3 = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
      f3 = i[14:12];
      f7 = i[31:25];
      f7_std = (f7 == 7'd0) || (f7 == 7'd32);
      ival = int'(i[31:20]);
      if (i[31]) ival -= 4096;
      sval = int'({i[31:25], i[11:7]});
      if (i[31]) sval -= 4096;
      bval = int'({i[31], i[7], i[30:25], i[11:8]}) * 2;
      if (i[31]) bval -= 8192;
      r = '0;
      care = '1;
      r.rs1 = i[19:15];
      r.rs2 = i[24:20];
      r.rd  = i[11:7];
      legal = 1'b1;
      case (i[6:0])
         7'h33: begin
            legal = f7_std;
            r.ctrl = by_f3[f3];
            if (f3 == 3'd0 && f7[5]) r.ctrl = C_SUB;
            if (f3 == 3'd5 && f7[5]) r.ctrl = C_SRA;
            r.rw = 1'b1;
            care.imm = '0;
         end
         7'h13: begin
            legal = !(f3 == 3'd1 || f3 == 3'd5) || f7_std;
            r.ctrl = by_f3[f3];
            if (f3 == 3'd5 && f7[5]) r.ctrl = C_SRA;
            r.src = 1'b1;
            r.imm = 32'(ival);
            r.rw  = 1'b1;
         end
         7'h03: begin
            r.ctrl = C_ADD; r.src = 1'b1; r.imm = 32'(ival); r.rw = 1'b1;
         end
         7'h23: begin
            r.ctrl = C_ADD; r.src = 1'b1; r.imm = 32'(sval);
         end
         7'h63: begin
            legal = (f3 != 3'd2) && (f3 != 3'd3);
            r.ctrl = (f3 < 3'd2) ? C_SUB : (f3 < 3'd6) ? C_SLT : C_SLTU;
            r.imm = 32'(bval);
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         r.ctrl = C_ADD; r.src = 1'b0; r.rw = 1'b0;
         care.imm = '0;
      end
      r.ill = ILL_EN && !legal;
      return r;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w;
      logic [6:0]  opc [8];
      int          sel;
      opc = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h00};
      w = $urandom;
      sel = $urandom_range(0, 7);
      if (sel != 7) begin
         w[6:0] = opc[sel];
         case ($urandom_range(0, 3))
            0: w[31:25] = 7'd0;
            1: w[31:25] = 7'd32;
            default: ;
         endcase
      end
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
      total++; if (got !== '0) begin bad++; $display("FAIL reset_payload got=%h want=0", got); end
   endtask

   task automatic test_addi();
      out_ready = 1'b1; in_valid = 1'b1; instr = 32'hFFB10093;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%0b want=1", out_valid); end
      total++; if (alu_ctrl !== C_ADD) begin bad++; $display("FAIL addi_ctrl got=%0d want=%0d", alu_ctrl, C_ADD); end
      total++; if (alu_src !== 1'b1) begin bad++; $display("FAIL addi_src got=%0b want=1", alu_src); end
      total++; if (imm !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_imm got=%h want=fffffffb", imm); end
      total++; if (rd !== 5'd1 || rs1 !== 5'd2) begin bad++; $display("FAIL addi_regs got rd=%0d rs1=%0d want 1/2", rd, rs1); end
      total++; if (reg_write !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL addi_flags got rw=%0b ill=%0b want 1/0", reg_write, illegal); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drained got=%0b want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1; in_valid = 1'b1; instr = 32'h402081B3;
      step();
      instr = 32'h40335293;
      total++; if (out_valid !== 1'b1 || alu_ctrl !== C_SUB || alu_src !== 1'b0 || rd !== 5'd3)
         begin bad++; $display("FAIL b2b_sub got v=%0b ctrl=%0d src=%0b rd=%0d want 1/%0d/0/3", out_valid, alu_ctrl, alu_src, rd, C_SUB); end
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || alu_ctrl !== C_SRA || alu_src !== 1'b1 || imm[4:0] !== 5'd3 || rd !== 5'd5)
         begin bad++; $display("FAIL b2b_srai got v=%0b ctrl=%0d src=%0b sh=%0d rd=%0d want 1/%0d/1/3/5", out_valid, alu_ctrl, alu_src, imm[4:0], rd, C_SRA); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%0b want=0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] seq [3];
      logic [4:0]  seen [$];
      seq = '{32'h00100093, 32'h00200113, 32'h00300193};   // ADDI x1/x2/x3
      out_ready = 1'b0;
      in_valid = 1'b1; instr = seq[0]; step();
      instr = seq[1]; step();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b want=0", in_ready); end
      instr = seq[2]; step();
      total++; if (in_ready !== 1'b0 || rd !== 5'd1) begin bad++; $display("FAIL bp_held got ready=%0b rd=%0d want 0/1", in_ready, rd); end
      out_ready = 1'b1;
      for (int c = 0; c < 8 && seen.size() < 4; c++) begin
         if (out_valid === 1'b1) seen.push_back(rd);
         if (in_ready === 1'b1 && in_valid) begin step(); in_valid = 1'b0; end
         else step();
      end
      out_ready = 1'b0;
      total++; if (seen.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", seen.size()); end
      total++; if (seen.size() < 3 || seen[0] !== 5'd1 || seen[1] !== 5'd2 || seen[2] !== 5'd3)
         begin bad++; $display("FAIL bp_order got=%p want 1,2,3", seen); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1;
      instr = 32'h00100093; step();
      instr = 32'h00200113; step();
      flush = 1'b1; instr = 32'h00700393; step();
      flush = 1'b0; in_valid = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got v=%0b r=%0b want 0/1", out_valid, in_ready); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_push_dropped got=%0b want=0", out_valid); end
   endtask

   task automatic test_undefined();
      out_ready = 1'b1; in_valid = 1'b1; instr = 32'h00000000;
      step();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || alu_ctrl !== C_ADD || reg_write !== 1'b0 || alu_src !== 1'b0)
         begin bad++; $display("FAIL undef_op got v=%0b ctrl=%0d rw=%0b src=%0b want 1/0/0/0", out_valid, alu_ctrl, reg_write, alu_src); end
      total++; if (illegal !== ILL_EN) begin bad++; $display("FAIL undef_illegal got=%0b want=%0b", illegal, ILL_EN); end
      instr = 32'h0000A063;   // BRANCH f3=010
      in_valid = 1'b1; step(); in_valid = 1'b0;
      total++; if (illegal !== ILL_EN || alu_ctrl !== C_ADD) begin bad++; $display("FAIL undef_branch got ill=%0b ctrl=%0d want %0b/0", illegal, alu_ctrl, ILL_EN); end
      step();
   endtask

   task automatic test_random();
      op_t exp_q [$];
      op_t care_q [$];
      op_t e, m;
      bit  do_push, do_pop, do_flush;
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         instr     = gen_instr();
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         total++; if (out_valid !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b want=%0b", c, out_valid, exp_q.size() != 0); end
         total++; if (in_ready !== (exp_q.size() != DEPTH)) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b want=%0b", c, in_ready, exp_q.size() != DEPTH); end
         if (exp_q.size() != 0) begin
            total++;
            if ((got & care_q[0]) !== (exp_q[0] & care_q[0])) begin
               bad++; $display("FAIL rnd_payload c=%0d got=%h want=%h", c, got & care_q[0], exp_q[0] & care_q[0]);
            end
         end
         do_flush = flush;
         do_push  = in_valid && (exp_q.size() != DEPTH) && !do_flush;
         do_pop   = (exp_q.size() != 0) && out_ready;
         e = ref_op(instr, m);
         step();
         if (do_flush) begin
            exp_q.delete(); care_q.delete();
         end else begin
            if (do_pop) begin void'(exp_q.pop_front()); void'(care_q.pop_front()); end
            if (do_push) begin exp_q.push_back(e); care_q.push_back(m); end
         end
      end
      in_valid = 1'b0; flush = 1'b1; out_ready = 1'b0;
      step();
      flush = 1'b0;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0; in_valid = 1'b1;
      instr = 32'h00100093; step();
      instr = 32'h00200113; step();
      in_valid = 1'b0; out_ready = 1'b1; step();
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b want=0", out_valid); end
      total++; if (got !== '0) begin bad++; $display("FAIL arst_payload got=%h want=0", got); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL arst_release got r=%0b v=%0b want 1/0", in_ready, out_valid); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_undefined();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
